game_session_ctrl: RTL

- Parametrised successor to the top-level game state controller. Owns the whole session lifecycle: lives, level progression, pellet-count win detection, scoring, the ghost-eat chain, and all global pause/reset timing.
- Sits between the maze/character blocks and the display and score path.
- Takes per-ghost collision and fright flags from any number of ghost instances. Does not instantiate characters.
- Clocked at the 60 Hz game tick, so every timer below is measured in frames.

---
 rtl/game_session_pkg.sv | 25 ++
 rtl/game_score.sv | 61 ++++++
 rtl/game_session_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/game_session_pkg.sv
// Shared types and constants for the game session controller and its score path.
package game_session_pkg;

    typedef enum logic [2:0] {
        StIdle       = 3'd0,
        StReady      = 3'd1,
        StPlay       = 3'd2,
        StEatFreeze  = 3'd3,
        StDying      = 3'd4,
        StLevelClear = 3'd5,
        StGameOver   = 3'd6
    } state_e;

    localparam int unsigned PTS_PELLET      = 10;
    localparam int unsigned PTS_POWER       = 50;
    localparam int unsigned PTS_GHOST_BASE  = 200;
    localparam int unsigned CHAIN_MAX       = 3;

    localparam int unsigned GHOST_ANIM_DIV  = 8;
    localparam int unsigned PELLET_ANIM_DIV = 16;
    localparam int unsigned ANIM_CNT_W      = 4;

    localparam int unsigned TIMER_W         = 16;

endpackage

// File: rtl/game_score.sv
// Saturating score accumulator with ghost eat-chain tracking and one-shot extra-life detect.
module game_score
    import game_session_pkg::*;
#(
    parameter int unsigned SCORE_W          = 18,
    parameter int unsigned EXTRA_LIFE_SCORE = 10000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               add_pellet_i,
    input  logic               add_power_i,
    input  logic               add_ghost_i,
    input  logic               chain_clear_i,
    output logic [SCORE_W-1:0] score_o,
    output logic [1:0]         eat_chain_o,
    output logic               extra_life_o
);

    localparam logic [SCORE_W:0] ExtraThr = (SCORE_W+1)'(EXTRA_LIFE_SCORE);

    logic [SCORE_W-1:0] score_q, score_d;
    logic [1:0]         chain_q, chain_d;
    logic               extra_done_q;
    logic [SCORE_W:0]   add_w, sum_w;

    always_comb begin
        add_w = '0;
        if (add_pellet_i) add_w = add_w + (SCORE_W+1)'(PTS_PELLET);
        if (add_power_i)  add_w = add_w + (SCORE_W+1)'(PTS_POWER);
        if (add_ghost_i)  add_w = add_w + ((SCORE_W+1)'(PTS_GHOST_BASE) << chain_q);
        // One spare bit catches the carry so the score clamps instead of wrapping.
        sum_w   = {1'b0, score_q} + add_w;
        score_d = sum_w[SCORE_W] ? '1 : sum_w[SCORE_W-1:0];

        chain_d = chain_q;
        if (chain_clear_i) begin
            chain_d = '0;
        end else if (add_ghost_i && chain_q != 2'(CHAIN_MAX)) begin
            chain_d = chain_q + 2'd1;
        end
    end

    assign extra_life_o = !extra_done_q && ({1'b0, score_q} >= ExtraThr);

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            score_q      <= '0;
            chain_q      <= '0;
            extra_done_q <= 1'b0;
        end else begin
            score_q <= score_d;
            chain_q <= chain_d;
            if (extra_life_o) extra_done_q <= 1'b1;
        end
    end

    assign score_o     = score_q;
    assign eat_chain_o = chain_q;

endmodule

// File: rtl/game_session_ctrl.sv
// Top-level session lifecycle controller: lives, levels, pellets, ghost eats and pause timing.
// Define HISCORE_EN to add the hi_score output.
module game_session_ctrl
    import game_session_pkg::*;
#(
    parameter int unsigned N_GHOSTS         = 4,
    parameter int unsigned TOTAL_PELLETS    = 244,
    parameter int unsigned START_LIVES      = 3,
    parameter int unsigned MAX_LIVES        = 5,
    parameter int unsigned EXTRA_LIFE_SCORE = 10000,
    parameter int unsigned SCORE_W          = 18,
    parameter int unsigned READY_TICKS      = 120,
    parameter int unsigned EAT_TICKS        = 60,
    parameter int unsigned DEATH_TICKS      = 90,
    parameter int unsigned CLEAR_TICKS      = 120
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                pellet_eaten,
    input  logic                power_eaten,
    input  logic [N_GHOSTS-1:0] ghost_hit,
    input  logic [N_GHOSTS-1:0] ghost_fright,
    output logic [N_GHOSTS-1:0] ghost_eat,
    output logic [2:0]          state,
    output logic                pause,
    output logic                reset_players,
    output logic [2:0]          lives,
    output logic [7:0]          level,
    output logic [SCORE_W-1:0]  score,
    output logic [8:0]          pellets_left,
    output logic [1:0]          eat_chain,
    output logic                ghost_anim,
    output logic                pellet_anim
`ifdef HISCORE_EN
    ,
    output logic [SCORE_W-1:0]  hi_score
`endif
);

    localparam logic [TIMER_W-1:0] ReadyLoad = TIMER_W'(READY_TICKS - 1);
    localparam logic [TIMER_W-1:0] EatLoad   = TIMER_W'(EAT_TICKS - 1);
    localparam logic [TIMER_W-1:0] DeathLoad = TIMER_W'(DEATH_TICKS - 1);
    localparam logic [TIMER_W-1:0] ClearLoad = TIMER_W'(CLEAR_TICKS - 1);

    state_e                state_q, state_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [2:0]            lives_q, lives_d, lives_bump;
    logic [7:0]            level_q, level_d;
    logic [8:0]            pellets_q, pellets_d, pellets_sub;
    logic [N_GHOSTS-1:0]   ghost_eat_q, eat_d, lethal, edible, eat_onehot;
    logic                  pause_q, reset_players_q, timer_done;
    logic                  new_game, add_pellet, add_power, add_ghost, chain_clear, extra_life;
    logic [1:0]            pellet_dec;
    logic [ANIM_CNT_W-1:0] ghost_cnt_q, pellet_cnt_q;
    logic                  ghost_anim_q, pellet_anim_q;
    logic [SCORE_W-1:0]    score_w;

    assign lethal      = ghost_hit & ~ghost_fright;
    assign edible      = ghost_hit & ghost_fright;
    assign eat_onehot  = edible & (~edible + N_GHOSTS'(1));
    assign timer_done  = (timer_q == '0);
    assign pellet_dec  = {1'b0, pellet_eaten} + {1'b0, power_eaten};
    assign pellets_sub = (pellets_q > 9'(pellet_dec)) ? pellets_q - 9'(pellet_dec) : '0;
    assign lives_bump  = (extra_life && lives_q < 3'(MAX_LIVES)) ? lives_q + 3'd1 : lives_q;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_done ? '0 : timer_q - TIMER_W'(1);
        lives_d     = lives_bump;
        level_d     = level_q;
        pellets_d   = pellets_q;
        eat_d       = '0;
        new_game    = 1'b0;
        add_pellet  = 1'b0;
        add_power   = 1'b0;
        add_ghost   = 1'b0;
        chain_clear = 1'b0;
        case (state_q)
            StIdle, StGameOver: begin
                if (start) begin
                    new_game  = 1'b1;
                    lives_d   = 3'(START_LIVES);
                    level_d   = 8'd1;
                    pellets_d = 9'(TOTAL_PELLETS);
                    state_d   = StReady;
                    timer_d   = ReadyLoad;
                end
            end
            StReady: if (timer_done) state_d = StPlay;
            StPlay: begin
                // Death outranks eating, which outranks pellet scoring.
                if (|lethal) begin
                    state_d = StDying;
                    timer_d = DeathLoad;
                end else if (|edible) begin
                    eat_d     = eat_onehot;
                    add_ghost = 1'b1;
                    state_d   = StEatFreeze;
                    timer_d   = EatLoad;
                end else begin
                    add_pellet  = pellet_eaten;
                    add_power   = power_eaten;
                    chain_clear = power_eaten;
                    pellets_d   = pellets_sub;
                    if (pellets_q == '0) begin
                        state_d = StLevelClear;
                        timer_d = ClearLoad;
                    end
                end
            end
            StEatFreeze: if (timer_done) state_d = StPlay;
            StDying: begin
                if (timer_done) begin
                    if (lives_q == 3'd1) begin
                        lives_d = '0;
                        state_d = StGameOver;
                    end else begin
                        lives_d = lives_bump - 3'd1;
                        state_d = StReady;
                        timer_d = ReadyLoad;
                    end
                end
            end
            StLevelClear: begin
                if (timer_done) begin
                    level_d     = (level_q == 8'hFF) ? level_q : level_q + 8'd1;
                    pellets_d   = 9'(TOTAL_PELLETS);
                    chain_clear = 1'b1;
                    state_d     = StReady;
                    timer_d     = ReadyLoad;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            timer_q         <= '0;
            lives_q         <= 3'(START_LIVES);
            level_q         <= 8'd1;
            pellets_q       <= 9'(TOTAL_PELLETS);
            ghost_eat_q     <= '0;
            pause_q         <= 1'b1;
            reset_players_q <= 1'b1;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            lives_q         <= lives_d;
            level_q         <= level_d;
            pellets_q       <= pellets_d;
            ghost_eat_q     <= eat_d;
            pause_q         <= (state_d != StPlay);
            reset_players_q <= (state_d == StIdle) || (state_d == StReady);
        end
    end

    // Ghost frames advance only while unpaused; pellet blink runs only in PLAY.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghost_cnt_q   <= '0;
            ghost_anim_q  <= 1'b0;
            pellet_cnt_q  <= '0;
            pellet_anim_q <= 1'b1;
        end else begin
            if (!pause_q) begin
                if (ghost_cnt_q == ANIM_CNT_W'(GHOST_ANIM_DIV - 1)) begin
                    ghost_cnt_q  <= '0;
                    ghost_anim_q <= ~ghost_anim_q;
                end else begin
                    ghost_cnt_q <= ghost_cnt_q + ANIM_CNT_W'(1);
                end
            end
            if (state_d != StPlay) begin
                pellet_cnt_q  <= '0;
                pellet_anim_q <= 1'b1;
            end else if (pellet_cnt_q == ANIM_CNT_W'(PELLET_ANIM_DIV - 1)) begin
                pellet_cnt_q  <= '0;
                pellet_anim_q <= ~pellet_anim_q;
            end else begin
                pellet_cnt_q <= pellet_cnt_q + ANIM_CNT_W'(1);
            end
        end
    end

    game_score #(
        .SCORE_W          (SCORE_W),
        .EXTRA_LIFE_SCORE (EXTRA_LIFE_SCORE)
    ) u_score (
        .clk_i         (clk),
        .rst_i         (rst),
        .clear_i       (new_game),
        .add_pellet_i  (add_pellet),
        .add_power_i   (add_power),
        .add_ghost_i   (add_ghost),
        .chain_clear_i (chain_clear),
        .score_o       (score_w),
        .eat_chain_o   (eat_chain),
        .extra_life_o  (extra_life)
    );

`ifdef HISCORE_EN
    logic [SCORE_W-1:0] hi_score_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_score_q <= '0;
        end else if (score_w > hi_score_q) begin
            hi_score_q <= score_w;
        end
    end

    assign hi_score = hi_score_q;
`else
    // Best-score tracking is left to the downstream score path in this build.
`endif

    assign state         = state_q;
    assign pause         = pause_q;
    assign reset_players = reset_players_q;
    assign lives         = lives_q;
    assign level         = level_q;
    assign score         = score_w;
    assign pellets_left  = pellets_q;
    assign ghost_eat     = ghost_eat_q;
    assign ghost_anim    = ghost_anim_q;
    assign pellet_anim   = pellet_anim_q;

endmodule
